// File: rtl/bpred_update_sched_pkg.sv
// Shared types for the branch predictor update scheduler: PHT counter encodings,
// scheduler states, control-flow opcodes and the saturating counter helper.
package bpred_update_sched_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } pht_ctr_e;

  localparam logic [1:0] PHT_RESET = 2'b11;

  typedef enum logic {
    S_INIT,
    S_RUN
  } sched_state_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic isCtrl(input logic [6:0] op);
    return (op == OPC_JAL) || (op == OPC_JALR) || (op == OPC_BRANCH);
  endfunction

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] phtNext(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == STRONG_T) ? STRONG_T : ctr + 2'd1;
    end
    return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Small synchronous FIFO holding pending predictor table updates.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bpred_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Storage is cleared on reset so the head never presents X to the read port.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (pop_i && !empty_o) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bpred_update_sched.sv
// Drives the gshare BTB/tag/PHT single write port: clears all entries after reset,
// then retires queued EX resolutions one per cycle while redirect/BHSR act immediately.
module bpred_update_sched
  import bpred_update_sched_pkg::*;
#(
  parameter int BTB_DEPTH = 32,
  parameter int IDX_WIDTH = $clog2(BTB_DEPTH),
  parameter int TAG_WIDTH = 30 - IDX_WIDTH,
  parameter int Q_DEPTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 res_valid_i,
  input  logic [6:0]           res_opcode_i,
  input  logic [31:0]          res_pc_i,
  input  logic [IDX_WIDTH-1:0] res_pht_idx_i,
  input  logic                 res_taken_i,
  input  logic [31:0]          res_target_i,
  input  logic [31:0]          res_pred_pc_i,
  output logic                 stall_o,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  output logic                 bhsr_shift_o,
  output logic                 bhsr_bit_o,
  output logic                 init_busy_o,
  output logic [IDX_WIDTH-1:0] pht_rd_idx_o,
  input  logic [1:0]           pht_rd_data_i,
  output logic                 tbl_we_btb_o,
  output logic [IDX_WIDTH-1:0] tbl_btb_idx_o,
  output logic [31:0]          tbl_btb_data_o,
  output logic [TAG_WIDTH-1:0] tbl_tag_data_o,
  output logic                 tbl_we_pht_o,
  output logic [IDX_WIDTH-1:0] tbl_pht_idx_o,
  output logic [1:0]           tbl_pht_data_o
);

  localparam int ENTRY_W = 30 + IDX_WIDTH + 1 + 32 + 32;

  sched_state_e         state_q, state_d;
  logic [IDX_WIDTH-1:0] initCnt_q, initCnt_d;

  logic                 ctrl, accept, pop, fifoFull, fifoEmpty;
  logic [31:0]          nextPc;
  logic [ENTRY_W-1:0]   fifoWdata, fifoRdata;
  logic [29:0]          headPcWord;
  logic [IDX_WIDTH-1:0] headIdx;
  logic                 headTaken;
  logic [31:0]          headTarget, headPred;

  assign ctrl   = res_valid_i && isCtrl(res_opcode_i);
  assign accept = ctrl && !fifoFull;
  assign nextPc = res_taken_i ? res_target_i : res_pc_i + 32'd4;

  assign stall_o          = ctrl && fifoFull;
  assign redirect_valid_o = accept && (nextPc != res_pred_pc_i);
  assign redirect_pc_o    = accept ? nextPc : 32'd0;
  assign bhsr_shift_o     = accept && (res_opcode_i == OPC_BRANCH);
  assign bhsr_bit_o       = res_taken_i;

  // Only the word address of the PC is needed for BTB index and tag.
  assign fifoWdata = {res_pc_i[31:2], res_pht_idx_i, res_taken_i, res_target_i, res_pred_pc_i};
  assign {headPcWord, headIdx, headTaken, headTarget, headPred} = fifoRdata;
  assign pht_rd_idx_o = headIdx;

  bpred_upd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (accept),
    .wdata_i (fifoWdata),
    .pop_i   (pop),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_INIT;
      initCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
    end
  end

  // Write enables are held low while reset is asserted so the port is quiet asynchronously.
  always_comb begin
    state_d        = state_q;
    initCnt_d      = initCnt_q;
    pop            = 1'b0;
    init_busy_o    = 1'b0;
    tbl_we_btb_o   = 1'b0;
    tbl_btb_idx_o  = '0;
    tbl_btb_data_o = 32'd0;
    tbl_tag_data_o = '0;
    tbl_we_pht_o   = 1'b0;
    tbl_pht_idx_o  = '0;
    tbl_pht_data_o = PHT_RESET;
    case (state_q)
      S_INIT: begin
        init_busy_o   = 1'b1;
        tbl_we_btb_o  = !reset_i;
        tbl_we_pht_o  = !reset_i;
        tbl_btb_idx_o = initCnt_q;
        tbl_pht_idx_o = initCnt_q;
        initCnt_d     = initCnt_q + IDX_WIDTH'(1);
        if (initCnt_q == IDX_WIDTH'(BTB_DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        pop = !fifoEmpty;
        if (pop) begin
          tbl_we_pht_o   = 1'b1;
          tbl_pht_idx_o  = headIdx;
          tbl_pht_data_o = phtNext(pht_rd_data_i, headTaken);
          tbl_we_btb_o   = headTaken && (headTarget != headPred);
          tbl_btb_idx_o  = headPcWord[IDX_WIDTH-1:0];
          tbl_btb_data_o = headTarget;
          tbl_tag_data_o = headPcWord[29:IDX_WIDTH];
        end
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule
